hpdc_mem_responder: RTL and testbench

HPDC_MEM_RESPONDER -- requirements
Module: hpdc_mem_responder

---
 rtl/hpdc_mem_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_hpdc_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdc_mem_responder.sv
// rtl/hpdc_mem_responder.sv - line-granular memory model answering HPDcache read/write bursts
package hpdcache_mem_pkg;
    localparam int HPDCACHE_MEM_ADDR_WIDTH = 32;
    localparam int HPDCACHE_MEM_ID_WIDTH   = 4;
    localparam int HPDCACHE_MEM_DATA_WIDTH = 64;
    localparam int HPDCACHE_MEM_BE_WIDTH   = HPDCACHE_MEM_DATA_WIDTH / 8;

    localparam logic [1:0] HPDCACHE_MEM_READ   = 2'd0;
    localparam logic [1:0] HPDCACHE_MEM_WRITE  = 2'd1;
    localparam logic [1:0] HPDCACHE_MEM_ATOMIC = 2'd2;

    localparam logic [1:0] HPDCACHE_MEM_RESP_OK  = 2'd0;
    localparam logic [1:0] HPDCACHE_MEM_RESP_NOK = 2'd2;

    typedef struct packed {
        logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] mem_req_addr;
        logic [7:0]                         mem_req_len;
        logic [2:0]                         mem_req_size;
        logic [HPDCACHE_MEM_ID_WIDTH-1:0]   mem_req_id;
        logic [1:0]                         mem_req_command;
    } hpdcache_mem_req_t;

    typedef struct packed {
        logic [1:0]                         mem_resp_r_error;
        logic [HPDCACHE_MEM_ID_WIDTH-1:0]   mem_resp_r_id;
        logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_resp_r_data;
        logic                               mem_resp_r_last;
    } hpdcache_mem_resp_r_t;

    typedef struct packed {
        logic [HPDCACHE_MEM_DATA_WIDTH-1:0] mem_req_w_data;
        logic [HPDCACHE_MEM_BE_WIDTH-1:0]   mem_req_w_be;
        logic                               mem_req_w_last;
    } hpdcache_mem_req_w_t;

    typedef struct packed {
        logic                               mem_resp_w_is_atomic;
        logic [1:0]                         mem_resp_w_error;
        logic [HPDCACHE_MEM_ID_WIDTH-1:0]   mem_resp_w_id;
    } hpdcache_mem_resp_w_t;
endpackage

module hpdc_mem_responder
    import hpdcache_mem_pkg::*;
#(
    parameter int unsigned                        MEM_DEPTH = 1024,
    parameter logic [HPDCACHE_MEM_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 mem_req_read_valid_i,
    output logic                 mem_req_read_ready_o,
    input  hpdcache_mem_req_t    mem_req_read_i,
    output logic                 mem_resp_read_valid_o,
    input  logic                 mem_resp_read_ready_i,
    output hpdcache_mem_resp_r_t mem_resp_read_o,
    input  logic                 mem_req_write_valid_i,
    output logic                 mem_req_write_ready_o,
    input  hpdcache_mem_req_t    mem_req_write_i,
    input  logic                 mem_req_write_data_valid_i,
    output logic                 mem_req_write_data_ready_o,
    input  hpdcache_mem_req_w_t  mem_req_write_data_i,
    output logic                 mem_resp_write_valid_o,
    input  logic                 mem_resp_write_ready_i,
    output hpdcache_mem_resp_w_t mem_resp_write_o
);
    localparam int AW    = HPDCACHE_MEM_ADDR_WIDTH;
    localparam int DW    = HPDCACHE_MEM_DATA_WIDTH;
    localparam int IDW   = HPDCACHE_MEM_ID_WIDTH;
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int OFF_W = $clog2(HPDCACHE_MEM_BE_WIDTH);

    // Line indices are kept address-wide so out-of-range requests never alias into the store.
    typedef logic [AW-1:0] idx_t;

    logic [DW-1:0] mem [MEM_DEPTH];

    function automatic logic idx_ok(input logic below, input idx_t idx);
        return !below && (idx < idx_t'(MEM_DEPTH));
    endfunction

    typedef enum logic {RD_IDLE, RD_BEAT} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

    rd_state_e      rd_state, rd_state_nx;
    logic [IDW-1:0] rd_id;
    idx_t           rd_idx, rd_nx_idx;
    logic [8:0]     rd_left;
    logic           rd_below, rd_last, rd_nx_below, rd_nx_bad, rd_nx_ok;
    logic [DW-1:0]  rd_data;
    logic [1:0]     rd_err;
    logic           rd_acc, rd_beat_acc;

    assign rd_acc      = mem_req_read_valid_i && (rd_state == RD_IDLE);
    assign rd_beat_acc = mem_resp_read_ready_i && (rd_state == RD_BEAT);

    always_comb begin
        rd_state_nx = rd_state;
        rd_nx_below = rd_below;
        rd_nx_idx   = rd_idx + idx_t'(1);
        rd_nx_bad   = 1'b0;
        if (rd_state == RD_IDLE) begin
            rd_nx_below = mem_req_read_i.mem_req_addr < BASE_ADDR;
            rd_nx_idx   = (mem_req_read_i.mem_req_addr - BASE_ADDR) >> OFF_W;
            rd_nx_bad   = mem_req_read_i.mem_req_command != HPDCACHE_MEM_READ;
            if (mem_req_read_valid_i) rd_state_nx = RD_BEAT;
        end else if (rd_beat_acc && rd_last) begin
            rd_state_nx = RD_IDLE;
        end
        rd_nx_ok = !rd_nx_bad && idx_ok(rd_nx_below, rd_nx_idx);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rd_state <= RD_IDLE;
        else         rd_state <= rd_state_nx;
    end

    // The beat is registered when presented so a later write to its line cannot disturb a stalled beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rd_id    <= '0;
            rd_idx   <= '0;
            rd_left  <= '0;
            rd_below <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
            rd_err   <= HPDCACHE_MEM_RESP_OK;
        end else if (rd_acc || (rd_beat_acc && !rd_last)) begin
            rd_idx  <= rd_nx_idx;
            rd_data <= rd_nx_ok ? mem[rd_nx_idx[IDX_W-1:0]] : '0;
            rd_err  <= rd_nx_ok ? HPDCACHE_MEM_RESP_OK : HPDCACHE_MEM_RESP_NOK;
            if (rd_acc) begin
                rd_id    <= mem_req_read_i.mem_req_id;
                rd_below <= rd_nx_below;
                rd_left  <= rd_nx_bad ? 9'd1 : {1'b0, mem_req_read_i.mem_req_len} + 9'd1;
                rd_last  <= rd_nx_bad || (mem_req_read_i.mem_req_len == 8'd0);
            end else begin
                rd_left <= rd_left - 9'd1;
                rd_last <= rd_left == 9'd2;
            end
        end
    end

    assign mem_req_read_ready_o  = rd_state == RD_IDLE;
    assign mem_resp_read_valid_o = rd_state == RD_BEAT;
    assign mem_resp_read_o       = '{mem_resp_r_error: rd_err, mem_resp_r_id: rd_id,
                                     mem_resp_r_data: rd_data, mem_resp_r_last: rd_last};

    wr_state_e      wr_state, wr_state_nx;
    logic [IDW-1:0] wr_id;
    idx_t           wr_idx;
    logic [8:0]     wr_exp, wr_cnt;
    logic           wr_below, wr_bad, wr_err;
    logic           wr_req_acc, wr_beat_acc, wr_beat_ok, wr_we;

    assign wr_req_acc  = mem_req_write_valid_i && (wr_state == WR_IDLE);
    assign wr_beat_acc = mem_req_write_data_valid_i && (wr_state == WR_DATA);
    assign wr_beat_ok  = !wr_bad && (wr_cnt < wr_exp) && idx_ok(wr_below, wr_idx);
    assign wr_we       = wr_beat_acc && wr_beat_ok;

    always_comb begin
        wr_state_nx = wr_state;
        case (wr_state)
            WR_IDLE: if (mem_req_write_valid_i) wr_state_nx = WR_DATA;
            WR_DATA: if (wr_beat_acc && mem_req_write_data_i.mem_req_w_last) wr_state_nx = WR_RESP;
            WR_RESP: if (mem_resp_write_ready_i) wr_state_nx = WR_IDLE;
            default: wr_state_nx = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) wr_state <= WR_IDLE;
        else         wr_state <= wr_state_nx;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_id    <= '0;
            wr_idx   <= '0;
            wr_exp   <= '0;
            wr_cnt   <= '0;
            wr_below <= 1'b0;
            wr_bad   <= 1'b0;
            wr_err   <= 1'b0;
        end else if (wr_req_acc) begin
            wr_id    <= mem_req_write_i.mem_req_id;
            wr_idx   <= (mem_req_write_i.mem_req_addr - BASE_ADDR) >> OFF_W;
            wr_below <= mem_req_write_i.mem_req_addr < BASE_ADDR;
            wr_bad   <= mem_req_write_i.mem_req_command != HPDCACHE_MEM_WRITE;
            wr_exp   <= {1'b0, mem_req_write_i.mem_req_len} + 9'd1;
            wr_cnt   <= '0;
            wr_err   <= 1'b0;
        end else if (wr_beat_acc) begin
            wr_idx <= wr_idx + idx_t'(1);
            // Saturate so a runaway stream stays flagged as beyond the expected count.
            if (wr_cnt != '1) wr_cnt <= wr_cnt + 9'd1;
            if (!wr_beat_ok || (mem_req_write_data_i.mem_req_w_last && (wr_cnt + 9'd1 != wr_exp)))
                wr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_we) begin
            for (int b = 0; b < HPDCACHE_MEM_BE_WIDTH; b++) begin
                if (mem_req_write_data_i.mem_req_w_be[b])
                    mem[wr_idx[IDX_W-1:0]][8*b +: 8] <= mem_req_write_data_i.mem_req_w_data[8*b +: 8];
            end
        end
    end

    assign mem_req_write_ready_o      = wr_state == WR_IDLE;
    assign mem_req_write_data_ready_o = wr_state == WR_DATA;
    assign mem_resp_write_valid_o     = wr_state == WR_RESP;
    assign mem_resp_write_o           = '{mem_resp_w_is_atomic: 1'b0,
                                          mem_resp_w_error: wr_err || wr_bad ? HPDCACHE_MEM_RESP_NOK
                                                                             : HPDCACHE_MEM_RESP_OK,
                                          mem_resp_w_id: wr_id};

    logic unused_bits;
    assign unused_bits = ^{mem_req_read_i.mem_req_size, mem_req_write_i.mem_req_size,
                           mem_req_read_i.mem_req_addr[OFF_W-1:0],
                           mem_req_write_i.mem_req_addr[OFF_W-1:0]};
endmodule

// File: tb/tb_hpdc_mem_responder.sv
// tb/tb_hpdc_mem_responder.sv - directed bench for hpdc_mem_responder
module tb_hpdc_mem_responder;
    import hpdcache_mem_pkg::*;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    localparam logic [63:0] D_A5   = {8{8'hA5}};
    localparam logic [63:0] D_CAFE = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] D_77   = {8{8'h77}};
    localparam logic [63:0] D_0    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_DEAD = 64'hDEAD_BEEF_0000_000F;
    localparam logic [63:0] P6     = 64'h6666_0000_6666_0000;
    localparam logic [63:0] P7     = 64'h7070_7070_0707_0707;
    localparam logic [63:0] N6     = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] P9     = 64'h9999_AAAA_9999_AAAA;
    localparam logic [63:0] N8     = 64'h8888_1234_8888_5678;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic                 rreq_valid, rreq_ready, rresp_valid, rresp_ready;
    hpdcache_mem_req_t    rreq;
    hpdcache_mem_resp_r_t rresp;
    logic                 wreq_valid, wreq_ready, wdata_valid, wdata_ready, wresp_valid, wresp_ready;
    hpdcache_mem_req_t    wreq;
    hpdcache_mem_req_w_t  wdata;
    hpdcache_mem_resp_w_t wresp;

    int vectors = 0;
    int errors  = 0;

    hpdc_mem_responder #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i                      (clk),
        .rstn_i                     (rstn),
        .mem_req_read_valid_i       (rreq_valid),
        .mem_req_read_ready_o       (rreq_ready),
        .mem_req_read_i             (rreq),
        .mem_resp_read_valid_o      (rresp_valid),
        .mem_resp_read_ready_i      (rresp_ready),
        .mem_resp_read_o            (rresp),
        .mem_req_write_valid_i      (wreq_valid),
        .mem_req_write_ready_o      (wreq_ready),
        .mem_req_write_i            (wreq),
        .mem_req_write_data_valid_i (wdata_valid),
        .mem_req_write_data_ready_o (wdata_ready),
        .mem_req_write_data_i       (wdata),
        .mem_resp_write_valid_o     (wresp_valid),
        .mem_resp_write_ready_i     (wresp_ready),
        .mem_resp_write_o           (wresp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] la(input int line);
        return BASE + 32'(line * 8);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] cmd);
        int n = 0;
        rreq = '{mem_req_addr: addr, mem_req_len: len, mem_req_size: 3'd3, mem_req_id: id,
                 mem_req_command: cmd};
        rreq_valid = 1'b1;
        while (!rreq_ready && n < 50) begin step(); n++; end
        chk("rd_req_ready", 64'(rreq_ready), 64'd1);
        step();
        rreq_valid = 1'b0;
    endtask

    task automatic rd_beat(input string tag, input logic [3:0] id, input logic [63:0] data,
                           input logic last, input logic [1:0] err);
        int n = 0;
        rresp_ready = 1'b1;
        while (!rresp_valid && n < 50) begin step(); n++; end
        chk({tag, "_valid"}, 64'(rresp_valid), 64'd1);
        chk({tag, "_id"}, 64'(rresp.mem_resp_r_id), 64'(id));
        chk({tag, "_data"}, rresp.mem_resp_r_data, data);
        chk({tag, "_last"}, 64'(rresp.mem_resp_r_last), 64'(last));
        chk({tag, "_err"}, 64'(rresp.mem_resp_r_error), 64'(err));
        step();
        rresp_ready = 1'b0;
    endtask

    task automatic wr_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] cmd);
        int n = 0;
        wreq = '{mem_req_addr: addr, mem_req_len: len, mem_req_size: 3'd3, mem_req_id: id,
                 mem_req_command: cmd};
        wreq_valid = 1'b1;
        while (!wreq_ready && n < 50) begin step(); n++; end
        chk("wr_req_ready", 64'(wreq_ready), 64'd1);
        step();
        wreq_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [63:0] data, input logic [7:0] be, input logic last);
        int n = 0;
        wdata = '{mem_req_w_data: data, mem_req_w_be: be, mem_req_w_last: last};
        wdata_valid = 1'b1;
        while (!wdata_ready && n < 50) begin step(); n++; end
        chk("wr_data_ready", 64'(wdata_ready), 64'd1);
        step();
        wdata_valid = 1'b0;
    endtask

    task automatic wr_resp(input string tag, input logic [3:0] id, input logic [1:0] err);
        int n = 0;
        wresp_ready = 1'b1;
        while (!wresp_valid && n < 50) begin step(); n++; end
        chk({tag, "_valid"}, 64'(wresp_valid), 64'd1);
        chk({tag, "_id"}, 64'(wresp.mem_resp_w_id), 64'(id));
        chk({tag, "_err"}, 64'(wresp.mem_resp_w_error), 64'(err));
        chk({tag, "_atomic"}, 64'(wresp.mem_resp_w_is_atomic), 64'd0);
        step();
        wresp_ready = 1'b0;
    endtask

    task automatic write_line(input int line, input logic [63:0] data);
        wr_req(4'd1, la(line), 8'd0, HPDCACHE_MEM_WRITE);
        wr_beat(data, 8'hFF, 1'b1);
        wr_resp("preload", 4'd1, HPDCACHE_MEM_RESP_OK);
    endtask

    logic [63:0] t3_exp [4];

    initial begin
        rreq_valid = 1'b0; rresp_ready = 1'b0; rreq = '0;
        wreq_valid = 1'b0; wdata_valid = 1'b0; wresp_ready = 1'b0; wreq = '0; wdata = '0;
        step();
        step();
        chk("rst_rreq_ready", 64'(rreq_ready), 64'd1);
        chk("rst_wreq_ready", 64'(wreq_ready), 64'd1);
        chk("rst_wdata_ready", 64'(wdata_ready), 64'd0);
        chk("rst_rresp_valid", 64'(rresp_valid), 64'd0);
        chk("rst_wresp_valid", 64'(wresp_valid), 64'd0);
        chk("rst_rresp", 64'(rresp), 64'd0);
        rstn = 1'b1;
        step();

        // Single-line write then read back, with one-cycle read latency.
        wr_req(4'd5, la(0), 8'd0, HPDCACHE_MEM_WRITE);
        wr_beat(D_A5, 8'hFF, 1'b1);
        wr_resp("t1_wresp", 4'd5, HPDCACHE_MEM_RESP_OK);
        rd_req(4'd3, la(0), 8'd0, HPDCACHE_MEM_READ);
        chk("t1_latency", 64'(rresp_valid), 64'd1);
        rd_beat("t1_rd", 4'd3, D_A5, 1'b1, HPDCACHE_MEM_RESP_OK);
        chk("t1_idle", 64'(rreq_ready), 64'd1);

        // Two-beat write, partial byte enables on beat 1.
        write_line(1, D_CAFE);
        write_line(3, D_77);
        wr_req(4'd2, la(2), 8'd1, HPDCACHE_MEM_WRITE);
        wr_beat(D_0, 8'hFF, 1'b0);
        wr_beat(64'h0000_0000_0000_00BB, 8'h01, 1'b1);
        wr_resp("t2_wresp", 4'd2, HPDCACHE_MEM_RESP_OK);
        rd_req(4'd6, la(2), 8'd1, HPDCACHE_MEM_READ);
        rd_beat("t2_b0", 4'd6, D_0, 1'b0, HPDCACHE_MEM_RESP_OK);
        rd_beat("t2_b1", 4'd6, 64'h7777_7777_7777_77BB, 1'b1, HPDCACHE_MEM_RESP_OK);

        // Four-beat read with response ready toggling 1,0,1,0.
        t3_exp = '{D_A5, D_CAFE, D_0, 64'h7777_7777_7777_77BB};
        rd_req(4'd7, la(0), 8'd3, HPDCACHE_MEM_READ);
        for (int i = 0; i < 7; i++) begin
            int b;
            b = (i + 1) / 2;
            rresp_ready = (i % 2) == 0;
            chk("t3_valid", 64'(rresp_valid), 64'd1);
            chk("t3_data", rresp.mem_resp_r_data, t3_exp[b]);
            chk("t3_id", 64'(rresp.mem_resp_r_id), 64'd7);
            chk("t3_last", 64'(rresp.mem_resp_r_last), 64'(b == 3));
            chk("t3_rreq_ready", 64'(rreq_ready), 64'd0);
            step();
        end
        rresp_ready = 1'b0;
        chk("t3_done_valid", 64'(rresp_valid), 64'd0);
        chk("t3_done_ready", 64'(rreq_ready), 64'd1);

        // Burst running off the end of the store.
        write_line(15, D_DEAD);
        rd_req(4'd8, la(15), 8'd1, HPDCACHE_MEM_READ);
        rd_beat("t4_b0", 4'd8, D_DEAD, 1'b0, HPDCACHE_MEM_RESP_OK);
        rd_beat("t4_b1", 4'd8, 64'd0, 1'b1, HPDCACHE_MEM_RESP_NOK);

        // Early-last write concurrent with a read burst.
        write_line(6, P6);
        write_line(7, P7);
        rreq = '{mem_req_addr: la(0), mem_req_len: 8'd1, mem_req_size: 3'd3, mem_req_id: 4'd9,
                 mem_req_command: HPDCACHE_MEM_READ};
        wreq = '{mem_req_addr: la(6), mem_req_len: 8'd1, mem_req_size: 3'd3, mem_req_id: 4'd7,
                 mem_req_command: HPDCACHE_MEM_WRITE};
        rreq_valid = 1'b1;
        wreq_valid = 1'b1;
        chk("t5_rreq_ready", 64'(rreq_ready), 64'd1);
        chk("t5_wreq_ready", 64'(wreq_ready), 64'd1);
        step();
        rreq_valid = 1'b0;
        wreq_valid = 1'b0;
        rresp_ready = 1'b1;
        wdata = '{mem_req_w_data: N6, mem_req_w_be: 8'hFF, mem_req_w_last: 1'b1};
        wdata_valid = 1'b1;
        chk("t5_wdata_ready", 64'(wdata_ready), 64'd1);
        chk("t5_rb0_valid", 64'(rresp_valid), 64'd1);
        chk("t5_rb0_data", rresp.mem_resp_r_data, D_A5);
        chk("t5_rb0_last", 64'(rresp.mem_resp_r_last), 64'd0);
        step();
        wdata_valid = 1'b0;
        chk("t5_rb1_valid", 64'(rresp_valid), 64'd1);
        chk("t5_rb1_data", rresp.mem_resp_r_data, D_CAFE);
        chk("t5_rb1_id", 64'(rresp.mem_resp_r_id), 64'd9);
        chk("t5_rb1_last", 64'(rresp.mem_resp_r_last), 64'd1);
        step();
        rresp_ready = 1'b0;
        wr_resp("t5_wresp", 4'd7, HPDCACHE_MEM_RESP_NOK);
        rd_req(4'd10, la(6), 8'd1, HPDCACHE_MEM_READ);
        rd_beat("t5_l6", 4'd10, N6, 1'b0, HPDCACHE_MEM_RESP_OK);
        rd_beat("t5_l7", 4'd10, P7, 1'b1, HPDCACHE_MEM_RESP_OK);

        // Wrong read command and address below the base.
        rd_req(4'd4, la(0), 8'd3, HPDCACHE_MEM_WRITE);
        rd_beat("t6_cmd", 4'd4, 64'd0, 1'b1, HPDCACHE_MEM_RESP_NOK);
        chk("t6_single_beat", 64'(rresp_valid), 64'd0);
        rd_req(4'd4, BASE - 32'd8, 8'd0, HPDCACHE_MEM_READ);
        rd_beat("t6_below", 4'd4, 64'd0, 1'b1, HPDCACHE_MEM_RESP_NOK);

        // Wrong write command, then a beat beyond the expected count.
        wr_req(4'd11, la(0), 8'd0, HPDCACHE_MEM_READ);
        wr_beat({8{8'hFF}}, 8'hFF, 1'b1);
        wr_resp("t7_cmd", 4'd11, HPDCACHE_MEM_RESP_NOK);
        write_line(9, P9);
        wr_req(4'd12, la(8), 8'd0, HPDCACHE_MEM_WRITE);
        wr_beat(N8, 8'hFF, 1'b0);
        wr_beat({8{8'h11}}, 8'hFF, 1'b1);
        wr_resp("t7_extra", 4'd12, HPDCACHE_MEM_RESP_NOK);
        rd_req(4'd13, la(8), 8'd1, HPDCACHE_MEM_READ);
        rd_beat("t7_l8", 4'd13, N8, 1'b0, HPDCACHE_MEM_RESP_OK);
        rd_beat("t7_l9", 4'd13, P9, 1'b1, HPDCACHE_MEM_RESP_OK);
        rd_req(4'd14, la(0), 8'd0, HPDCACHE_MEM_READ);
        rd_beat("t7_l0", 4'd14, D_A5, 1'b1, HPDCACHE_MEM_RESP_OK);

        // Reset during beat 2 of a four-beat read.
        rd_req(4'd15, la(0), 8'd3, HPDCACHE_MEM_READ);
        rresp_ready = 1'b1;
        step();
        step();
        chk("t8_beat2_data", rresp.mem_resp_r_data, D_0);
        rstn = 1'b0;
        step();
        chk("t8_rst_rvalid", 64'(rresp_valid), 64'd0);
        chk("t8_rst_wvalid", 64'(wresp_valid), 64'd0);
        chk("t8_rst_rready", 64'(rreq_ready), 64'd1);
        chk("t8_rst_wdready", 64'(wdata_ready), 64'd0);
        rresp_ready = 1'b0;
        rstn = 1'b1;
        step();
        chk("t8_post_rready", 64'(rreq_ready), 64'd1);
        chk("t8_post_rvalid", 64'(rresp_valid), 64'd0);
        rd_req(4'd1, la(2), 8'd0, HPDCACHE_MEM_READ);
        rd_beat("t8_after", 4'd1, D_0, 1'b1, HPDCACHE_MEM_RESP_OK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
